// File: rtl/dispense_pkg.sv
// Shared types and default sizes for the inlet dispense sequencer.
package dispense_pkg;

    localparam int N_CH_DEF  = 3;
    localparam int CNT_W_DEF = 16;
    localparam int CH_W      = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPENSE,
        S_GAP,
        S_SETTLE,
        S_SAMPLE
    } state_t;

endpackage

// File: rtl/inlet_dispense_seq_period_timer.sv
// Loadable down-counter; tc_o is high in the cycle the count is 1.
module period_timer
    import dispense_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;

    // Count register: load has priority, then count down to zero and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == W'(1));

endmodule

// File: rtl/inlet_dispense_seq.sv
// Inlet dispense sequencer: pump steps per channel, settle, then sample strobe.
// Optional macro DISPENSE_TOTAL_EN adds the total_steps pulse counter output.
module inlet_dispense_seq
    import dispense_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int STEP_PERIOD   = 100,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_steps,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  valve_open,
    output logic [N_CH-1:0]  pump_step,
    output logic             sample_strobe
`ifdef DISPENSE_TOTAL_EN
    ,
    output logic [CNT_W+1:0] total_steps
`endif
);

    localparam int TMAX = (STEP_PERIOD > SETTLE_CYCLES) ? STEP_PERIOD : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t            state_q;
    logic [CH_W-1:0]   ch_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [N_CH-1:0]   valve_q;
    logic [N_CH-1:0]   pump_q;
    logic              done_q;
    logic              strobe_q;
    logic              tmr_load_q;
    logic [TW-1:0]     tmr_val_q;
    logic              tc_s;
    logic              cfg_write_s;
    logic              first_found_s, next_found_s, go_found_s;
    logic [CH_W-1:0]   first_ch_s, next_ch_s, go_ch_s;

    assign cfg_ready     = (state_q == S_IDLE) && !start;
    assign cfg_write_s   = cfg_valid && cfg_ready && (32'(cfg_ch) < N_CH);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign sample_strobe = strobe_q;
    assign valve_open    = valve_q;
    assign pump_step     = pump_q;

    // The timer load is registered, so it takes effect one cycle after entry.
    period_timer #(.W(TW)) u_tmr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_q),
        .load_val_i (tmr_val_q),
        .tc_o       (tc_s)
    );

    // Channel selection: lowest nonzero channel overall and above the current one.
    always_comb begin
        first_found_s = 1'b0;
        first_ch_s    = '0;
        next_found_s  = 1'b0;
        next_ch_s     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (cnt_q[i] != '0) begin
                first_found_s = 1'b1;
                first_ch_s    = CH_W'(i);
            end else begin
                first_found_s = first_found_s;
            end
            if ((cnt_q[i] != '0) && (CH_W'(i) > ch_q)) begin
                next_found_s = 1'b1;
                next_ch_s    = CH_W'(i);
            end else begin
                next_found_s = next_found_s;
            end
        end
        go_found_s = (state_q == S_GAP) ? next_found_s : first_found_s;
        go_ch_s    = (state_q == S_GAP) ? next_ch_s : first_ch_s;
    end

    // Sequencer FSM with registered outputs and the per-channel count store.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            rem_q      <= '0;
            valve_q    <= '0;
            pump_q     <= '0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
            tmr_load_q <= 1'b0;
            tmr_val_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pump_q     <= '0;
            done_q     <= 1'b0;
            strobe_q   <= 1'b0;
            tmr_load_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_write_s && (cfg_ch == CH_W'(i))) begin
                    cnt_q[i] <= cfg_steps;
                end
            end
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                valve_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_GAP: begin
                        if ((state_q == S_GAP) || start) begin
                            tmr_load_q <= 1'b1;
                            if (go_found_s) begin
                                state_q   <= S_DISPENSE;
                                ch_q      <= go_ch_s;
                                valve_q   <= N_CH'(1) << go_ch_s;
                                rem_q     <= cnt_q[go_ch_s];
                                tmr_val_q <= TW'(STEP_PERIOD - 1);
                            end else begin
                                state_q   <= S_SETTLE;
                                valve_q   <= '0;
                                tmr_val_q <= TW'(SETTLE_CYCLES - 1);
                            end
                        end
                    end
                    S_DISPENSE: begin
                        // A pending load means the timer still holds a stale count.
                        if (!tmr_load_q && tc_s) begin
                            pump_q <= valve_q;
                            if (rem_q != '0) begin
                                rem_q <= rem_q - CNT_W'(1);
                            end
                            if (rem_q > CNT_W'(1)) begin
                                tmr_load_q <= 1'b1;
                                tmr_val_q  <= TW'(STEP_PERIOD - 1);
                            end
                        end else if ((pump_q != '0) && (rem_q == '0)) begin
                            state_q <= S_GAP;
                            valve_q <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (tmr_load_q ? (SETTLE_CYCLES == 1) : tc_s) begin
                            state_q  <= S_SAMPLE;
                            done_q   <= 1'b1;
                            strobe_q <= 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        valve_q <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DISPENSE_TOTAL_EN
    logic [CNT_W+1:0] total_q;

    // Pulse counter for the current run; cleared when a run is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            total_q <= '0;
        end else if (pump_q != '0) begin
            total_q <= total_q + (CNT_W + 2)'(1);
        end else begin
            total_q <= total_q;
        end
    end

    assign total_steps = total_q;
`endif

endmodule
